// File: rtl/sa_result_drain_if.sv
// sa_result_drain_if: 32-bit valid/ready result stream from the drain toward writeback/DMA.
// Signals: m_data (word), m_row (source row), m_valid, m_ready (sink accept), m_last (final row of frame).
// Modports: master (drain side) drives everything except m_ready; slave is the mirror.
interface sa_result_drain_if #(
    parameter int ROW_W = 3
);
    logic [31:0]      m_data;
    logic [ROW_W-1:0] m_row;
    logic             m_valid;
    logic             m_ready;
    logic             m_last;
    modport master (output m_data, m_row, m_valid, m_last, input m_ready);
    modport slave  (input m_data, m_row, m_valid, m_last, output m_ready);
endinterface

// File: rtl/sa_result_drain.sv
// sa_result_drain: snapshots systolic-array row results and serialises valid rows onto a stream.
// Ports: clk, rst (async, active-high); routport/rvalidport in from the core, outread pulse back;
// s (stream master: m_data/m_row/m_valid/m_ready/m_last); busy (in DRAIN); frame_cnt (completed frames).
module sa_result_drain #(
    parameter int ROWS  = 8,
    parameter int ROW_W = $clog2(ROWS),
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       routport [0:ROWS-1],
    input  logic [0:ROWS-1]   rvalidport,
    output logic              outread,
    sa_result_drain_if.master s,
    output logic              busy,
    output logic [CNT_W-1:0]  frame_cnt
);
    typedef enum logic {IDLE, DRAIN} state_t;
    state_t           state, state_nxt;
    logic [31:0]      res_buf [0:ROWS-1];
    logic [0:ROWS-1]  mask;
    logic [ROW_W-1:0] ptr;
    logic             last, capture, fire;
    assign capture = state == IDLE && |rvalidport;
    assign fire    = state == DRAIN && s.m_ready;
    // Lowest pending row: scan downward so the smallest set index wins.
    always_comb begin
        ptr = '0;
        for (int i = ROWS - 1; i >= 0; i--)
            if (mask[i]) ptr = ROW_W'(i);
    end
    always_comb begin
        last = 1'b1;
        for (int i = 0; i < ROWS; i++)
            if (mask[i] && ROW_W'(i) > ptr) last = 1'b0;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    always_comb begin
        state_nxt = state;
        if (capture)           state_nxt = DRAIN;
        else if (fire && last) state_nxt = IDLE;
    end
    always_comb begin
        busy      = state == DRAIN;
        s.m_valid = state == DRAIN;
        s.m_data  = s.m_valid ? res_buf[ptr] : '0;
        s.m_row   = s.m_valid ? ptr : '0;
        s.m_last  = s.m_valid && last;
    end
    // outread is registered from the capture decision, so it lands exactly on the first DRAIN cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_buf   <= '{default: '0};
            mask      <= '0;
            outread   <= 1'b0;
            frame_cnt <= '0;
        end else begin
            outread <= capture;
            if (capture) begin
                res_buf <= routport;
                mask    <= rvalidport;
            end else if (fire) begin
                mask[ptr] <= 1'b0;
                if (last) frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sa_result_drain.sv
// tb_sa_result_drain: scoreboard bench for sa_result_drain (ROWS=8).
module tb_sa_result_drain;
    typedef struct {
        logic [31:0] d;
        logic [2:0]  r;
        logic        l;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] routport [0:7];
    logic [0:7]  rvalidport;
    logic        outread;
    logic        busy;
    logic [15:0] frame_cnt;
    exp_t        q[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          exp_frames = 0;

    sa_result_drain_if #(.ROW_W(3)) sif ();

    sa_result_drain #(.ROWS(8), .CNT_W(16)) dut (
        .clk(clk),
        .rst(rst),
        .routport(routport),
        .rvalidport(rvalidport),
        .outread(outread),
        .s(sif),
        .busy(busy),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic present(input logic [0:7] v, input logic [31:0] vals [0:7]);
        int hi = -1;
        for (int i = 0; i < 8; i++) begin
            routport[i] = vals[i];
            if (v[i]) hi = i;
        end
        for (int i = 0; i < 8; i++)
            if (v[i]) q.push_back('{d: vals[i], r: 3'(i), l: (i == hi)});
        rvalidport = v;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        rvalidport = '1;
        sif.m_ready = 1'b1;
        for (int i = 0; i < 8; i++) routport[i] = 32'(i + 1);
        repeat (3) begin
            @(negedge clk);
            n_chk++;
            if ({outread, sif.m_valid, sif.m_data, sif.m_row, sif.m_last, busy, frame_cnt} !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs got or=%b v=%b d=%h r=%0d l=%b busy=%b fc=%0d, expected all 0",
                         outread, sif.m_valid, sif.m_data, sif.m_row, sif.m_last, busy, frame_cnt);
            end
        end
        rvalidport = '0;
        rst = 1'b0;
        @(negedge clk);
        n_chk++;
        if ({outread, sif.m_valid, busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_idle got or=%b v=%b busy=%b, expected 000", outread, sif.m_valid, busy);
        end
    endtask

    task automatic test_full;
        logic [31:0] vals [0:7];
        int cyc = 0, pulses = 0, first = -1, acc = 0, last_cyc = -1;
        for (int i = 0; i < 8; i++) vals[i] = 32'(100 + i);
        present(8'hFF, vals);
        sif.m_ready = 1'b1;
        while (q.size() > 0 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (outread) begin pulses++; if (first < 0) first = cyc; rvalidport = '0; end
            if (sif.m_valid) begin
                n_chk++;
                if (q.size() == 0 || {sif.m_data, sif.m_row, sif.m_last} !== {q[0].d, q[0].r, q[0].l}) begin
                    n_fail++;
                    $display("FAIL full_word got d=%h r=%0d l=%b, expected d=%h r=%0d l=%b",
                             sif.m_data, sif.m_row, sif.m_last, q[0].d, q[0].r, q[0].l);
                end
                if (q.size() > 0) begin q.delete(0); acc++; last_cyc = cyc; end
            end
        end
        exp_frames++;
        @(negedge clk);
        n_chk++;
        if (acc != 8 || last_cyc != 8) begin n_fail++; $display("FAIL full_count got words=%0d end_cycle=%0d, expected 8 and 8", acc, last_cyc); end
        n_chk++;
        if (pulses != 1 || first != 1) begin n_fail++; $display("FAIL full_outread got pulses=%0d at=%0d, expected 1 at 1", pulses, first); end
        n_chk++;
        if (frame_cnt !== 16'(exp_frames) || busy !== 1'b0) begin n_fail++; $display("FAIL full_frame_cnt got fc=%0d busy=%b, expected %0d and 0", frame_cnt, busy, exp_frames); end
    endtask

    task automatic test_sparse;
        logic [31:0] vals [0:7];
        logic [0:7] v = '0;
        int cyc = 0, pulses = 0, acc = 0, last_cyc = -1;
        for (int i = 0; i < 8; i++) vals[i] = 32'hDEAD0000 | 32'(i);
        v[2] = 1'b1;
        v[5] = 1'b1;
        present(v, vals);
        while (q.size() > 0 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (outread) begin pulses++; rvalidport = '0; end
            if (sif.m_valid) begin
                n_chk++;
                if (q.size() == 0 || {sif.m_data, sif.m_row, sif.m_last} !== {q[0].d, q[0].r, q[0].l}) begin
                    n_fail++;
                    $display("FAIL sparse_word got d=%h r=%0d l=%b, expected d=%h r=%0d l=%b",
                             sif.m_data, sif.m_row, sif.m_last, q[0].d, q[0].r, q[0].l);
                end
                if (q.size() > 0) begin q.delete(0); acc++; last_cyc = cyc; end
            end
        end
        exp_frames++;
        @(negedge clk);
        n_chk++;
        if (acc != 2 || last_cyc != 2 || pulses != 1) begin n_fail++; $display("FAIL sparse_count got words=%0d end=%0d pulses=%0d, expected 2 2 1", acc, last_cyc, pulses); end
        n_chk++;
        if (frame_cnt !== 16'(exp_frames) || sif.m_valid !== 1'b0) begin n_fail++; $display("FAIL sparse_frame_cnt got fc=%0d v=%b, expected %0d and 0", frame_cnt, sif.m_valid, exp_frames); end
    endtask

    task automatic test_backpressure;
        logic [31:0] vals [0:7];
        int cyc = 0, pulses = 0, acc = 0, last_cyc = -1;
        for (int i = 0; i < 8; i++) vals[i] = 32'(100 + i);
        present(8'hFF, vals);
        while (q.size() > 0 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            sif.m_ready = cyc % 2 == 0;
            if (outread) begin pulses++; rvalidport = '0; end
            if (cyc > 1) for (int i = 0; i < 8; i++) routport[i] = $urandom;
            if (sif.m_valid) begin
                n_chk++;
                if (q.size() == 0 || {sif.m_data, sif.m_row, sif.m_last} !== {q[0].d, q[0].r, q[0].l}) begin
                    n_fail++;
                    $display("FAIL bp_word cyc=%0d got d=%h r=%0d l=%b, expected d=%h r=%0d l=%b",
                             cyc, sif.m_data, sif.m_row, sif.m_last, q[0].d, q[0].r, q[0].l);
                end
                if (sif.m_ready && q.size() > 0) begin q.delete(0); acc++; last_cyc = cyc; end
            end
        end
        exp_frames++;
        sif.m_ready = 1'b1;
        @(negedge clk);
        n_chk++;
        if (acc != 8 || last_cyc != 16 || pulses != 1) begin n_fail++; $display("FAIL bp_count got words=%0d end=%0d pulses=%0d, expected 8 16 1", acc, last_cyc, pulses); end
        n_chk++;
        if (frame_cnt !== 16'(exp_frames)) begin n_fail++; $display("FAIL bp_frame_cnt got %0d, expected %0d", frame_cnt, exp_frames); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] v1 [0:7];
        logic [31:0] v2 [0:7];
        int cyc = 0, pulses = 0, p2 = -1, acc = 0, last1 = -1;
        bit presented = 0;
        for (int i = 0; i < 8; i++) begin v1[i] = 32'(100 + i); v2[i] = 32'(200 + i); end
        present(8'hFF, v1);
        sif.m_ready = 1'b1;
        while ((q.size() > 0 || !presented) && cyc < 80) begin
            @(negedge clk);
            cyc++;
            if (outread) begin pulses++; if (pulses == 2) p2 = cyc; rvalidport = '0; end
            else if (pulses == 1 && !presented) begin present(8'hFF, v2); presented = 1; end
            if (sif.m_valid) begin
                n_chk++;
                if (q.size() == 0 || {sif.m_data, sif.m_row, sif.m_last} !== {q[0].d, q[0].r, q[0].l}) begin
                    n_fail++;
                    $display("FAIL b2b_word got d=%h r=%0d l=%b, expected d=%h r=%0d l=%b",
                             sif.m_data, sif.m_row, sif.m_last, q[0].d, q[0].r, q[0].l);
                end
                if (q.size() > 0) begin
                    if (q[0].l && last1 < 0) last1 = cyc;
                    q.delete(0);
                    acc++;
                end
            end
        end
        exp_frames += 2;
        @(negedge clk);
        n_chk++;
        if (acc != 16 || pulses != 2) begin n_fail++; $display("FAIL b2b_count got words=%0d pulses=%0d, expected 16 2", acc, pulses); end
        n_chk++;
        if (last1 != 8 || p2 != 10) begin n_fail++; $display("FAIL b2b_gap got last_row7=%0d second_outread=%0d, expected 8 10", last1, p2); end
        n_chk++;
        if (frame_cnt !== 16'(exp_frames)) begin n_fail++; $display("FAIL b2b_frame_cnt got %0d, expected %0d", frame_cnt, exp_frames); end
    endtask

    task automatic test_reset_mid_drain;
        logic [31:0] vals [0:7];
        int cyc = 0, pulses = 0, first = -1, acc = 0;
        for (int i = 0; i < 8; i++) vals[i] = 32'(300 + i);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_frames = 0;
        @(negedge clk);
        present(8'hFF, vals);
        sif.m_ready = 1'b1;
        while (acc < 3 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (outread) rvalidport = '0;
            if (sif.m_valid && q.size() > 0) begin q.delete(0); acc++; end
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_chk++;
        if ({sif.m_valid, busy, outread} !== 3'b000 || frame_cnt !== 16'(exp_frames)) begin
            n_fail++;
            $display("FAIL mid_reset got v=%b busy=%b or=%b fc=%0d, expected 0 0 0 %0d", sif.m_valid, busy, outread, frame_cnt, exp_frames);
        end
        q.delete();
        rvalidport = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            n_chk++;
            if (outread !== 1'b0 || sif.m_valid !== 1'b0) begin n_fail++; $display("FAIL mid_no_outread got or=%b v=%b, expected 0 0", outread, sif.m_valid); end
        end
        for (int i = 0; i < 8; i++) vals[i] = 32'(400 + i);
        present(8'hFF, vals);
        cyc = 0;
        acc = 0;
        while (q.size() > 0 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (outread) begin pulses++; if (first < 0) first = cyc; rvalidport = '0; end
            if (sif.m_valid) begin
                n_chk++;
                if (q.size() == 0 || {sif.m_data, sif.m_row, sif.m_last} !== {q[0].d, q[0].r, q[0].l}) begin
                    n_fail++;
                    $display("FAIL mid_word got d=%h r=%0d l=%b, expected d=%h r=%0d l=%b",
                             sif.m_data, sif.m_row, sif.m_last, q[0].d, q[0].r, q[0].l);
                end
                if (q.size() > 0) begin q.delete(0); acc++; end
            end
        end
        exp_frames++;
        @(negedge clk);
        n_chk++;
        if (acc != 8 || pulses != 1 || first != 1) begin n_fail++; $display("FAIL mid_redrain got words=%0d pulses=%0d at=%0d, expected 8 1 1", acc, pulses, first); end
        n_chk++;
        if (frame_cnt !== 16'(exp_frames)) begin n_fail++; $display("FAIL mid_frame_cnt got %0d, expected %0d", frame_cnt, exp_frames); end
    endtask

    initial begin
        test_reset();
        test_full();
        test_sparse();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
